alu_muldiv: RTL

Parametrised RV32IM/RV64IM execute unit: single-cycle integer ALU plus an iterative radix-4 Booth multiplier and restoring divider behind one valid/ready handshake. It sits in the execute stage, takes decoded operands and a 5-bit op select, and returns one registered result per accepted op. It replaces the level-sensitive ready scheme with an explicit in/out handshake, adds MULH*/DIV*/REM*, and defines all RISC-V corner cases.

---
 rtl/alu_muldiv.sv | 305 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: RV32IM/RV64IM execute unit.
//   Single-cycle integer ALU, iterative radix-4 Booth multiplier and restoring
//   divider behind one in/out valid/ready handshake. One registered result per
//   accepted op. A new op is only taken in IDLE.
//
// Parameters: XLEN (32 or 64), SHW = $clog2(XLEN) (derived).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/in_ready   op handshake (in_ready = IDLE)
//   sel[4:0]        op select
//   dataA, dataB    operands (A = rs1 / dividend / multiplicand)
//   out_valid/out_ready result handshake
//   dataD           result, illegal = unsupported sel (sideband of dataD)
//
// Build option: ALU_MULDIV_DIV_EN -- when defined the divider is present;
// otherwise DIV/DIVU/REM/REMU report illegal with base-op latency.
module alu_muldiv #(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      sel,
    input  logic [XLEN-1:0] dataA,
    input  logic [XLEN-1:0] dataB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] dataD,
    output logic            illegal
);
    localparam int W  = XLEN + 2;           // extended multiplier operand width
    localparam int CW = $clog2(XLEN + 1);

    localparam logic [4:0] OP_ADD  = 5'h00, OP_SLL  = 5'h01, OP_SLT  = 5'h02,
                           OP_SLTU = 5'h03, OP_XOR  = 5'h04, OP_SRL  = 5'h05,
                           OP_OR   = 5'h06, OP_AND  = 5'h07, OP_SUB  = 5'h08,
                           OP_NE   = 5'h09, OP_EQ   = 5'h0A, OP_GE   = 5'h0B,
                           OP_GEU  = 5'h0C, OP_SRA  = 5'h0D,
                           OP_MUL  = 5'h10, OP_MULH = 5'h11, OP_MULHSU = 5'h12,
                           OP_MULHU = 5'h13;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4:0]        op_q, op_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              illegal_q, illegal_d;
    logic [W-1:0]      mul_m_q, mul_m_d;
    logic [W+1:0]      mul_acc_q, mul_acc_d;
    logic [W-1:0]      mul_b_q, mul_b_d;
    logic              mul_bm1_q, mul_bm1_d;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign dataD     = result_q;
    assign illegal   = illegal_q;

    // One radix-4 Booth digit: add the recoded partial product into the
    // upper half, then arithmetic-shift {acc, b, b[-1]} right by two.
    function automatic logic [2*W+2:0] booth_step(input logic [W+1:0] acc,
                                                  input logic [W-1:0] b,
                                                  input logic         bm1,
                                                  input logic [W-1:0] m);
        logic [W+1:0] mx, pp, sum;
        mx = {{2{m[W-1]}}, m};
        case ({b[1:0], bm1})
            3'b001, 3'b010: pp = mx;
            3'b011:         pp = mx << 1;
            3'b100:         pp = -(mx << 1);
            3'b101, 3'b110: pp = -mx;
            default:        pp = '0;
        endcase
        sum = acc + pp;
        return {{2{sum[W+1]}}, sum[W+1:2], sum[1:0], b[W-1:2], b[1]};
    endfunction

    // ---------------- base ALU ----------------
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic [SHW-1:0]  shamt;
    assign shamt = dataB[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (sel)
            OP_ADD:  alu_res = dataA + dataB;
            OP_SUB:  alu_res = dataA - dataB;
            OP_SLL:  alu_res = dataA << shamt;
            OP_SRL:  alu_res = dataA >> shamt;
            OP_SRA:  alu_res = XLEN'($signed(dataA) >>> shamt);
            OP_SLT:  alu_res = XLEN'($signed(dataA) < $signed(dataB));
            OP_SLTU: alu_res = XLEN'(dataA < dataB);
            OP_GE:   alu_res = XLEN'($signed(dataA) >= $signed(dataB));
            OP_GEU:  alu_res = XLEN'(dataA >= dataB);
            OP_EQ:   alu_res = XLEN'(dataA == dataB);
            OP_NE:   alu_res = XLEN'(dataA != dataB);
            OP_XOR:  alu_res = dataA ^ dataB;
            OP_OR:   alu_res = dataA | dataB;
            OP_AND:  alu_res = dataA & dataB;
            default: alu_ill = 1'b1;   // includes M ops when routed here
        endcase
    end

    // ---------------- multiplier step ----------------
    logic            is_mul, a_sgn, b_sgn;
    logic [W-1:0]    a_ext, b_ext;
    logic [W+1:0]    st_acc_in, st_acc;
    logic [W-1:0]    st_b_in, st_m_in, st_b;
    logic            st_bm1_in, st_bm1;

    assign is_mul = (sel[4:2] == 3'b100);
    assign a_sgn  = (sel == OP_MULH) || (sel == OP_MULHSU);
    assign b_sgn  = (sel == OP_MULH);
    assign a_ext  = {{2{a_sgn & dataA[XLEN-1]}}, dataA};
    assign b_ext  = {{2{b_sgn & dataB[XLEN-1]}}, dataB};

    // The accept cycle retires the first digit from the live operands, so the
    // W/2 digits fit in the accept cycle plus XLEN/2 cycles in S_MUL.
    always_comb begin
        if (state_q == S_IDLE) begin
            st_acc_in = '0;
            st_b_in   = b_ext;
            st_bm1_in = 1'b0;
            st_m_in   = a_ext;
        end else begin
            st_acc_in = mul_acc_q;
            st_b_in   = mul_b_q;
            st_bm1_in = mul_bm1_q;
            st_m_in   = mul_m_q;
        end
        {st_acc, st_b, st_bm1} = booth_step(st_acc_in, st_b_in, st_bm1_in, st_m_in);
    end

`ifdef ALU_MULDIV_DIV_EN
    // ---------------- divider ----------------
    logic [XLEN-1:0] div_rem_q, div_rem_d;
    logic [XLEN-1:0] div_quo_q, div_quo_d;
    logic [XLEN-1:0] div_dsr_q, div_dsr_d;
    logic            div_qneg_q, div_qneg_d;
    logic            div_rneg_q, div_rneg_d;
    logic            is_div, a_neg, b_neg;
    logic [XLEN:0]   div_sh, div_diff;
    logic [XLEN-1:0] div_q_fin, div_r_fin;

    assign is_div    = (sel[4:2] == 3'b101);
    assign a_neg     = !sel[0] && dataA[XLEN-1];
    assign b_neg     = !sel[0] && dataB[XLEN-1];
    assign div_sh    = {div_rem_q, div_quo_q[XLEN-1]};
    assign div_diff  = div_sh - {1'b0, div_dsr_q};
    assign div_q_fin = div_qneg_q ? -div_quo_q : div_quo_q;
    assign div_r_fin = div_rneg_q ? -div_rem_q : div_rem_q;
`endif

    // ---------------- control ----------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        illegal_d   = illegal_q;
        mul_m_d     = mul_m_q;
        mul_acc_d   = mul_acc_q;
        mul_b_d     = mul_b_q;
        mul_bm1_d   = mul_bm1_q;
`ifdef ALU_MULDIV_DIV_EN
        div_rem_d   = div_rem_q;
        div_quo_d   = div_quo_q;
        div_dsr_d   = div_dsr_q;
        div_qneg_d  = div_qneg_q;
        div_rneg_d  = div_rneg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = sel;
                    if (is_mul) begin
                        mul_m_d   = a_ext;
                        mul_acc_d = st_acc;
                        mul_b_d   = st_b;
                        mul_bm1_d = st_bm1;
                        cnt_d     = CW'(XLEN/2 - 1);
                        state_d   = S_MUL;
                    end
`ifdef ALU_MULDIV_DIV_EN
                    else if (is_div && dataB == '0) begin
                        result_d    = sel[1] ? dataA : '1;
                        illegal_d   = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (is_div && !sel[0] && dataB == '1 &&
                                 dataA == {1'b1, {(XLEN-1){1'b0}}}) begin
                        result_d    = sel[1] ? '0 : dataA;
                        illegal_d   = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (is_div) begin
                        // Accept cycle strips the signs; they are reapplied
                        // in the final cycle.
                        div_quo_d  = a_neg ? -dataA : dataA;
                        div_dsr_d  = b_neg ? -dataB : dataB;
                        div_rem_d  = '0;
                        div_qneg_d = a_neg ^ b_neg;
                        div_rneg_d = a_neg;
                        cnt_d      = CW'(XLEN);
                        state_d    = S_DIV;
                    end
`endif
                    else begin
                        result_d    = alu_res;
                        illegal_d   = alu_ill;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_MUL: begin
                mul_acc_d = st_acc;
                mul_b_d   = st_b;
                mul_bm1_d = st_bm1;
                if (cnt_q == '0) begin
                    result_d    = (op_q == OP_MUL) ? st_b[XLEN-1:0]
                                                   : {st_acc[XLEN-3:0], st_b[W-1:XLEN]};
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef ALU_MULDIV_DIV_EN
            S_DIV: begin
                if (cnt_q != '0) begin
                    // Restoring step: keep the trial difference only if no borrow.
                    if (!div_diff[XLEN]) begin
                        div_rem_d = div_diff[XLEN-1:0];
                        div_quo_d = {div_quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        div_rem_d = div_sh[XLEN-1:0];
                        div_quo_d = {div_quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    result_d    = op_q[1] ? div_r_fin : div_q_fin;
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
            mul_m_q     <= '0;
            mul_acc_q   <= '0;
            mul_b_q     <= '0;
            mul_bm1_q   <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
            div_rem_q   <= '0;
            div_quo_q   <= '0;
            div_dsr_q   <= '0;
            div_qneg_q  <= 1'b0;
            div_rneg_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            illegal_q   <= illegal_d;
            mul_m_q     <= mul_m_d;
            mul_acc_q   <= mul_acc_d;
            mul_b_q     <= mul_b_d;
            mul_bm1_q   <= mul_bm1_d;
`ifdef ALU_MULDIV_DIV_EN
            div_rem_q   <= div_rem_d;
            div_quo_q   <= div_quo_d;
            div_dsr_q   <= div_dsr_d;
            div_qneg_q  <= div_qneg_d;
            div_rneg_q  <= div_rneg_d;
`endif
        end
    end
endmodule
